// File: rtl/fetch_queue_pkg.sv
// Shared entry layout for the fetch queue; the packed entry is also what fetch builds.
// Field order fixes the bit offsets below, MSB first.
package fetch_queue_pkg;

    localparam int ENTRY_W = 102;

    localparam int OFS_PC           = 0;
    localparam int OFS_INST         = 32;
    localparam int OFS_PREDICT_ADDR = 64;
    localparam int OFS_PREDICT      = 96;
    localparam int OFS_KERNEL       = 97;
    localparam int OFS_PAGING       = 98;
    localparam int OFS_FAULT_INV    = 99;
    localparam int OFS_FAULT_PRIV   = 100;
    localparam int OFS_FAULT_PF     = 101;

    typedef struct packed {
        logic        fault_pf;
        logic        fault_priv;
        logic        fault_inv;
        logic        paging;
        logic        kernel;
        logic        predict;
        logic [31:0] predict_addr;
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    typedef enum logic {
        FENCE_OPEN   = 1'b0,
        FENCE_FENCED = 1'b1
    } fence_t;

    function automatic logic entry_has_fault(input entry_t e);
        return e.fault_pf | e.fault_priv | e.fault_inv;
    endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage: DEPTH x entry register array.
// Latency: write lands on the clock edge, read is combinational from the array.
// Backpressure: none here; the caller only asserts we when a push is accepted.
module fetch_queue_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DEPTH_N = 2
) (
    input  logic               iCLOCK,
    input  logic               we,
    input  logic [DEPTH_N-1:0] waddr,
    input  entry_t             wdata,
    input  logic [DEPTH_N-1:0] raddr,
    output entry_t             rdata
);

    entry_t mem [DEPTH];

    // Contents are never reset; the top masks the head while the queue is empty.
    always_ff @(posedge iCLOCK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode, with a fence after faulting entries.
// Latency: a pushed entry reaches the head one cycle later; no same-cycle bypass.
// Backpressure: oPREVIOUS_LOCK = full || fenced, from registered state only.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DEPTH_N = 2
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic               iFREE_DEFAULT,
    input  logic               iPREVIOUS_INST_VALID,
    input  logic               iPREVIOUS_FAULT_PAGEFAULT,
    input  logic               iPREVIOUS_FAULT_PRIVILEGE_ERROR,
    input  logic               iPREVIOUS_FAULT_INVALID_INST,
    input  logic               iPREVIOUS_PAGING_ENA,
    input  logic               iPREVIOUS_KERNEL_ACCESS,
    input  logic               iPREVIOUS_BRANCH_PREDICT,
    input  logic [31:0]        iPREVIOUS_BRANCH_PREDICT_ADDR,
    input  logic [31:0]        iPREVIOUS_INST,
    input  logic [31:0]        iPREVIOUS_PC,
    output logic               oPREVIOUS_LOCK,
    output logic               oNEXT_INST_VALID,
    output logic               oNEXT_FAULT_PAGEFAULT,
    output logic               oNEXT_FAULT_PRIVILEGE_ERROR,
    output logic               oNEXT_FAULT_INVALID_INST,
    output logic               oNEXT_PAGING_ENA,
    output logic               oNEXT_KERNEL_ACCESS,
    output logic               oNEXT_BRANCH_PREDICT,
    output logic [31:0]        oNEXT_BRANCH_PREDICT_ADDR,
    output logic [31:0]        oNEXT_INST,
    output logic [31:0]        oNEXT_PC,
    input  logic               iNEXT_LOCK,
    output logic [DEPTH_N:0]   oINFO_COUNT
);

    localparam logic [DEPTH_N:0] FULL_CNT = (DEPTH_N+1)'(DEPTH);

    logic [DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_N:0]   count_q,  count_d;
    fence_t             fence_q,  fence_d;

    entry_t in_entry;
    entry_t ram_rdata;
    entry_t head;
    logic   not_empty;
    logic   full;
    logic   push;
    logic   pop;

    assign in_entry = '{
        fault_pf:     iPREVIOUS_FAULT_PAGEFAULT,
        fault_priv:   iPREVIOUS_FAULT_PRIVILEGE_ERROR,
        fault_inv:    iPREVIOUS_FAULT_INVALID_INST,
        paging:       iPREVIOUS_PAGING_ENA,
        kernel:       iPREVIOUS_KERNEL_ACCESS,
        predict:      iPREVIOUS_BRANCH_PREDICT,
        predict_addr: iPREVIOUS_BRANCH_PREDICT_ADDR,
        inst:         iPREVIOUS_INST,
        pc:           iPREVIOUS_PC
    };

    assign not_empty      = (count_q != '0);
    assign full           = (count_q == FULL_CNT);
    assign oPREVIOUS_LOCK = full || (fence_q == FENCE_FENCED);
    assign push           = iPREVIOUS_INST_VALID && !oPREVIOUS_LOCK;
    assign pop            = not_empty && !iNEXT_LOCK;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        fence_d  = fence_q;
        if (iFREE_DEFAULT) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            fence_d  = FENCE_OPEN;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            // The faulting entry is still queued; only later fetches are fenced.
            if (push && entry_has_fault(in_entry)) begin
                fence_d = FENCE_FENCED;
            end
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fence_q  <= FENCE_OPEN;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fence_q  <= fence_d;
        end
    end

    fetch_queue_ram #(
        .DEPTH   (DEPTH),
        .DEPTH_N (DEPTH_N)
    ) u_ram (
        .iCLOCK (iCLOCK),
        .we     (push && !iFREE_DEFAULT),
        .waddr  (wr_ptr_q),
        .wdata  (in_entry),
        .raddr  (rd_ptr_q),
        .rdata  (ram_rdata)
    );

    assign head = not_empty ? ram_rdata : '0;

    assign oNEXT_INST_VALID            = not_empty;
    assign oNEXT_FAULT_PAGEFAULT       = head.fault_pf;
    assign oNEXT_FAULT_PRIVILEGE_ERROR = head.fault_priv;
    assign oNEXT_FAULT_INVALID_INST    = head.fault_inv;
    assign oNEXT_PAGING_ENA            = head.paging;
    assign oNEXT_KERNEL_ACCESS         = head.kernel;
    assign oNEXT_BRANCH_PREDICT        = head.predict;
    assign oNEXT_BRANCH_PREDICT_ADDR   = head.predict_addr;
    assign oNEXT_INST                  = head.inst;
    assign oNEXT_PC                    = head.pc;
    assign oINFO_COUNT                 = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: inputs change 1ns after the rising edge,
// outputs are sampled just before the next rising edge.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        free;
    logic        p_vld, p_pf, p_priv, p_inv, p_paging, p_kernel, p_pred;
    logic [31:0] p_paddr, p_inst, p_pc;
    logic        p_lock;
    logic        n_vld, n_pf, n_priv, n_inv, n_paging, n_kernel, n_pred;
    logic [31:0] n_paddr, n_inst, n_pc;
    logic        n_lock;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .DEPTH_N(2)) dut (
        .iCLOCK                          (clk),
        .inRESET                         (rst_n),
        .iFREE_DEFAULT                   (free),
        .iPREVIOUS_INST_VALID            (p_vld),
        .iPREVIOUS_FAULT_PAGEFAULT       (p_pf),
        .iPREVIOUS_FAULT_PRIVILEGE_ERROR (p_priv),
        .iPREVIOUS_FAULT_INVALID_INST    (p_inv),
        .iPREVIOUS_PAGING_ENA            (p_paging),
        .iPREVIOUS_KERNEL_ACCESS         (p_kernel),
        .iPREVIOUS_BRANCH_PREDICT        (p_pred),
        .iPREVIOUS_BRANCH_PREDICT_ADDR   (p_paddr),
        .iPREVIOUS_INST                  (p_inst),
        .iPREVIOUS_PC                    (p_pc),
        .oPREVIOUS_LOCK                  (p_lock),
        .oNEXT_INST_VALID                (n_vld),
        .oNEXT_FAULT_PAGEFAULT           (n_pf),
        .oNEXT_FAULT_PRIVILEGE_ERROR     (n_priv),
        .oNEXT_FAULT_INVALID_INST        (n_inv),
        .oNEXT_PAGING_ENA                (n_paging),
        .oNEXT_KERNEL_ACCESS             (n_kernel),
        .oNEXT_BRANCH_PREDICT            (n_pred),
        .oNEXT_BRANCH_PREDICT_ADDR       (n_paddr),
        .oNEXT_INST                      (n_inst),
        .oNEXT_PC                        (n_pc),
        .iNEXT_LOCK                      (n_lock),
        .oINFO_COUNT                     (count)
    );

    // Advance one edge; inputs may then be changed safely.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to just before the next rising edge for sampling.
    task automatic settle();
        #3;
    endtask

    task automatic present(input logic vld, input logic [31:0] pc, input logic [31:0] inst,
                           input logic pf);
        p_vld   = vld;
        p_pc    = pc;
        p_inst  = inst;
        p_pf    = pf;
        p_priv  = 1'b0;
        p_inv   = 1'b0;
        p_paging = 1'b0;
        p_kernel = 1'b0;
        p_pred  = 1'b0;
        p_paddr = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; free = 1'b0; n_lock = 1'b0;
        present(1'b0, 32'h0, 32'h0, 1'b0);
        #12;
        checks++;
        if ({n_vld, p_lock, count} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: vld/lock/count=%b, want 00000", {n_vld, p_lock, count});
        end
        checks++;
        if ({n_pf, n_priv, n_inv, n_paging, n_kernel, n_pred, n_paddr, n_inst, n_pc} !== 102'h0) begin
            errors++; $display("FAIL reset_payload: pc=%h inst=%h, want all zero", n_pc, n_inst);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        present(1'b1, 32'h100, 32'hA5A5A5A5, 1'b0);
        p_paging = 1'b1; p_pred = 1'b1; p_paddr = 32'h1234;
        step();
        present(1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        checks++;
        if ({n_vld, count} !== 4'b1_001) begin
            errors++; $display("FAIL single_valid: vld,count=%b, want 1001", {n_vld, count});
        end
        checks++;
        if (n_pc !== 32'h100 || n_inst !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL single_payload: pc=%h inst=%h, want 100 a5a5a5a5", n_pc, n_inst);
        end
        checks++;
        if ({n_paging, n_kernel, n_pred, n_pf} !== 4'b1010 || n_paddr !== 32'h1234) begin
            errors++; $display("FAIL single_attr: pg/k/pr/pf=%b addr=%h, want 1010 1234",
                               {n_paging, n_kernel, n_pred, n_pf}, n_paddr);
        end
        step();
        settle();
        checks++;
        if ({n_vld, count} !== 4'b0 || n_pc !== 32'h0) begin
            errors++; $display("FAIL single_pop: vld,count=%b pc=%h, want 0000 0", {n_vld, count}, n_pc);
        end
        step();
    endtask

    task automatic fill4();
        n_lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            present(1'b1, 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0);
            step();
        end
        present(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_fill();
        fill4();
        settle();
        checks++;
        if ({p_lock, count} !== 4'b1_100) begin
            errors++; $display("FAIL fill_full: lock,count=%b, want 1100", {p_lock, count});
        end
        step();
        present(1'b1, 32'h99, 32'h99, 1'b0);
        step();
        present(1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        checks++;
        if (count !== 3'd4 || n_pc !== 32'h0) begin
            errors++; $display("FAIL fill_reject: count=%0d head=%h, want 4 0", count, n_pc);
        end
        step();
        n_lock = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++;
            if (n_pc !== 32'(4 * i) || n_inst !== 32'hC0DE_0000 + 32'(i) || n_vld !== 1'b1) begin
                errors++; $display("FAIL fill_order%0d: pc=%h inst=%h vld=%b, want %h", i, n_pc, n_inst, n_vld, 4 * i);
            end
            step();
        end
        settle();
        checks++;
        if ({n_vld, count, p_lock} !== 5'b0) begin
            errors++; $display("FAIL fill_drained: vld,count,lock=%b, want 00000", {n_vld, count, p_lock});
        end
        step();
    endtask

    task automatic test_full_pop();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h8; exp_pc[1] = 32'hC; exp_pc[2] = 32'h10;
        fill4();
        present(1'b1, 32'h10, 32'h1010, 1'b0);
        n_lock = 1'b0;
        settle();
        checks++;
        if (p_lock !== 1'b1 || n_pc !== 32'h0) begin
            errors++; $display("FAIL fullpop_before: lock=%b head=%h, want 1 0", p_lock, n_pc);
        end
        step();
        settle();
        checks++;
        if ({p_lock, count} !== 4'b0_011 || n_pc !== 32'h4) begin
            errors++; $display("FAIL fullpop_after: lock,count=%b head=%h, want 0011 4", {p_lock, count}, n_pc);
        end
        step();
        present(1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (n_pc !== exp_pc[i] || count !== 3'(3 - i)) begin
                errors++; $display("FAIL wrap_order%0d: pc=%h count=%0d, want %h %0d", i, n_pc, count, exp_pc[i], 3 - i);
            end
            step();
        end
        settle();
        checks++;
        if (count !== 3'd0) begin
            errors++; $display("FAIL wrap_drained: count=%0d, want 0", count);
        end
        step();
    endtask

    task automatic test_fault();
        n_lock = 1'b1;
        present(1'b1, 32'h200, 32'hDEAD, 1'b1);
        step();
        present(1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        checks++;
        if ({p_lock, count, n_pf} !== 5'b1_001_1 || n_pc !== 32'h200) begin
            errors++; $display("FAIL fault_fence: lock,count,pf=%b pc=%h, want 10011 200", {p_lock, count, n_pf}, n_pc);
        end
        step();
        n_lock = 1'b0;
        p_vld = 1'b1;
        step();
        p_vld = 1'b0;
        step();
        settle();
        checks++;
        if ({p_lock, count, n_vld} !== 5'b1_000_0) begin
            errors++; $display("FAIL fault_hold: lock,count,vld=%b, want 10000", {p_lock, count, n_vld});
        end
        step();
        free = 1'b1;
        step();
        free = 1'b0;
        settle();
        checks++;
        if (p_lock !== 1'b0) begin
            errors++; $display("FAIL fault_release: lock=%b, want 0", p_lock);
        end
        step();
    endtask

    task automatic test_flush();
        n_lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(1'b1, 32'h300 + 32'(4 * i), 32'h77, (i == 2) ? 1'b1 : 1'b0);
            step();
        end
        present(1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        checks++;
        if ({p_lock, count} !== 4'b1_011) begin
            errors++; $display("FAIL flush_pre: lock,count=%b, want 1011", {p_lock, count});
        end
        step();
        free = 1'b1; n_lock = 1'b0;
        present(1'b1, 32'h3F0, 32'h3F0, 1'b0);
        step();
        free = 1'b0;
        present(1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        checks++;
        if ({n_vld, count, p_lock} !== 5'b0 ||
            {n_pf, n_priv, n_inv, n_paging, n_kernel, n_pred, n_paddr, n_inst, n_pc} !== 102'h0) begin
            errors++; $display("FAIL flush_clear: vld,count,lock=%b pc=%h, want 00000 0", {n_vld, count, p_lock}, n_pc);
        end
        step();
    endtask

    task automatic test_async_reset();
        n_lock = 1'b1;
        for (int i = 0; i < 2; i++) begin
            present(1'b1, 32'h500 + 32'(i), 32'h55, 1'b0);
            step();
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({n_vld, count, p_lock} !== 5'b0 || n_pc !== 32'h0) begin
            errors++; $display("FAIL areset_now: vld,count,lock=%b pc=%h, want 00000 0", {n_vld, count, p_lock}, n_pc);
        end
        present(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        n_lock = 1'b0;
        step();
        present(1'b1, 32'h400, 32'h4444, 1'b0);
        step();
        present(1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        checks++;
        if ({n_vld, count} !== 4'b1_001 || n_pc !== 32'h400) begin
            errors++; $display("FAIL areset_restart: vld,count=%b pc=%h, want 1001 400", {n_vld, count}, n_pc);
        end
        step();
        settle();
        checks++;
        if (count !== 3'd0) begin
            errors++; $display("FAIL areset_drain: count=%0d, want 0", count);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_pop();
        test_fault();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue directly upstream of the decode stage.
- Buffers fetched instruction words with their fault, paging and branch-prediction attributes, and presents the head entry to decode using the lock-style handshake.
- Decouples fetch latency from decode stalls.
- Fences further fetch after a faulting entry until the pipeline is flushed.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- DEPTH_N, 2, log2(DEPTH); pointer width.

Ports:
- iCLOCK  in  1  core clock.
- inRESET  in  1  asynchronous active-low reset.
- iFREE_DEFAULT  in  1  synchronous pipeline flush.
- iPREVIOUS_INST_VALID  in  1  fetch presents an entry.
- iPREVIOUS_FAULT_PAGEFAULT / iPREVIOUS_FAULT_PRIVILEGE_ERROR / iPREVIOUS_FAULT_INVALID_INST  in  1 each  fetch fault flags.
- iPREVIOUS_PAGING_ENA / iPREVIOUS_KERNEL_ACCESS / iPREVIOUS_BRANCH_PREDICT  in  1 each  attributes.
- iPREVIOUS_BRANCH_PREDICT_ADDR / iPREVIOUS_INST / iPREVIOUS_PC  in  32 each  payload.
- oPREVIOUS_LOCK  out  1  fetch must hold its entry.
- oNEXT_INST_VALID  out  1  head entry valid.
- oNEXT_FAULT_PAGEFAULT / oNEXT_FAULT_PRIVILEGE_ERROR / oNEXT_FAULT_INVALID_INST / oNEXT_PAGING_ENA / oNEXT_KERNEL_ACCESS / oNEXT_BRANCH_PREDICT  out  1 each  head attributes.
- oNEXT_BRANCH_PREDICT_ADDR / oNEXT_INST / oNEXT_PC  out  32 each  head payload.
- iNEXT_LOCK  in  1  decode stalled.
- oINFO_COUNT  out  DEPTH_N+1  current occupancy.

Behaviour:
- Reset: iCLOCK plus inRESET, asynchronous active-low reset. On reset, pointers, count and fence clear; all outputs are 0; oPREVIOUS_LOCK is 0.
- Entry: 102 bits = 3 fault bits, paging, kernel, predict, predict address, instruction, PC.
- Push: occurs iff iPREVIOUS_INST_VALID && !oPREVIOUS_LOCK. The entry is written at the write pointer and becomes visible at the head one cycle later at the earliest (latency 1, no same-cycle bypass).
- Pop: occurs iff oNEXT_INST_VALID && !iNEXT_LOCK. Decode captures the head on that edge and the read pointer advances.
- oNEXT_INST_VALID = (count != 0). When the queue is empty, all oNEXT payload and attribute outputs are forced to 0.
- oPREVIOUS_LOCK = full || fence. It is a function of registered state only and never combinational on iNEXT_LOCK.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full plus pop: the push is rejected because lock is high that cycle; the next cycle lock drops.
- Pointers: DEPTH_N bits, natural wrap. count is DEPTH_N+1 bits, 0..DEPTH.
- Fence state machine, states OPEN and FENCED:
  - OPEN -> FENCED on a push whose entry has any fault bit set.
  - FENCED -> OPEN only on iFREE_DEFAULT.
  - The faulting entry itself is queued and delivered normally. Pops continue while FENCED.
- Flush: iFREE_DEFAULT has priority over push and pop. On the next edge, pointers, count and fence clear; any push or pop that cycle is discarded. Outputs read empty (all 0) the following cycle.
- Flush during reset is irrelevant; reset wins. A reset mid-operation drops all entries.
- oINFO_COUNT reflects the registered count.

Decomposition:
- core.h: entry-width constant and bit-field offsets for the packed entry, shared with fetch.
- One natural sub-module: fetch_queue_ram, a DEPTH x 102 register array with synchronous write and asynchronous read.
- Control logic (pointers, count, fence) stays in the top module.

Test Plan:
- Reset, then push PC 0x100, INST 0xA5A5A5A5 with iNEXT_LOCK=0 -> next cycle oNEXT_INST_VALID=1, oNEXT_PC=0x100; popped the same edge; count returns to 0.
- iNEXT_LOCK=1, push 4 entries PC 0x0/0x4/0x8/0xC -> oPREVIOUS_LOCK=1 after the 4th. A 5th valid push is not accepted. Release the lock -> 0x0, 0x4, 0x8, 0xC popped in order.
- Full queue, lock released, 5th entry PC 0x10 held -> pop of 0x0 happens with lock high that cycle. 0x10 is accepted the next cycle; order is preserved across pointer wrap.
- Push an entry with iPREVIOUS_FAULT_PAGEFAULT=1 at PC 0x200 -> fence set, oPREVIOUS_LOCK=1 with count 1. Fault entry delivered with fault bit 1; lock stays 1 until iFREE_DEFAULT.
- 3 entries queued, assert iFREE_DEFAULT together with a push and a pop -> next cycle count=0, oNEXT_INST_VALID=0, all outputs 0, fence cleared.
- Drop inRESET asynchronously mid-burst -> outputs 0 immediately; after release, the queue accepts new entries starting empty.
